// File: rtl/uart_fifo_core.sv
// Full-duplex UART with 16x-oversampled receiver, transmitter and FWFT RX/TX FIFOs.
// Framing: start, DATA_BITS LSB first, optional parity, one stop bit.
module uart_fifo_buf #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DW-1:0]              wr_data,
    input  logic                       rd_en,
    output logic [DW-1:0]              rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_wr, do_rd;

    assign full  = (count_reg == FULL_CNT);
    assign do_rd = rd_en && (count_reg != '0);
    // A write into a full buffer is fine when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;
endmodule

module uart_fifo_core #(
    parameter int CLK_DIV    = 13,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            rx,
    output logic                            tx,
    input  logic [DATA_BITS-1:0]            tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] tx_count,
    output logic                            rx_overrun,
    output logic                            rx_frame_err,
    output logic                            rx_parity_err,
    input  logic                            err_clear
);
    localparam int DIVW = $clog2(CLK_DIV + 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam bit HAS_PARITY = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;

    logic [DIVW-1:0] div_reg;
    logic            tick;
    logic            rx_meta_reg, rx_sync_reg;
    logic            rx_full, rx_push, rx_pop, tx_pop, tx_full;
    logic            set_overrun, set_frame, set_parity;
    logic            overrun_reg, frame_err_reg, parity_err_reg;
    logic [DATA_BITS-1:0] tx_head;

    uart_state_t          rx_state_reg, rx_state_next, tx_state_reg, tx_state_next;
    logic [3:0]           rx_tick_reg, rx_tick_next, tx_tick_reg, tx_tick_next;
    logic [2:0]           rx_bit_reg, rx_bit_next, tx_bit_reg, tx_bit_next;
    logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next, tx_shift_reg, tx_shift_next;
    logic                 rx_par_bad_reg, rx_par_bad_next;
    logic                 tx_par_reg, tx_par_next, tx_reg, tx_next;

    assign tick = (div_reg == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg        <= '0;
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            overrun_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            rx_state_reg   <= S_IDLE;
            rx_tick_reg    <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_par_bad_reg <= 1'b0;
            tx_state_reg   <= S_IDLE;
            tx_tick_reg    <= '0;
            tx_bit_reg     <= '0;
            tx_shift_reg   <= '0;
            tx_par_reg     <= 1'b0;
            tx_reg         <= 1'b1;
        end else begin
            div_reg        <= tick ? '0 : div_reg + DIVW'(1);
            rx_meta_reg    <= rx;
            rx_sync_reg    <= rx_meta_reg;
            // A new error in the same cycle as err_clear wins.
            overrun_reg    <= set_overrun | (overrun_reg & ~err_clear);
            frame_err_reg  <= set_frame   | (frame_err_reg & ~err_clear);
            parity_err_reg <= set_parity  | (parity_err_reg & ~err_clear);
            rx_state_reg   <= rx_state_next;
            rx_tick_reg    <= rx_tick_next;
            rx_bit_reg     <= rx_bit_next;
            rx_shift_reg   <= rx_shift_next;
            rx_par_bad_reg <= rx_par_bad_next;
            tx_state_reg   <= tx_state_next;
            tx_tick_reg    <= tx_tick_next;
            tx_bit_reg     <= tx_bit_next;
            tx_shift_reg   <= tx_shift_next;
            tx_par_reg     <= tx_par_next;
            tx_reg         <= tx_next;
        end
    end

    always_comb begin
        rx_state_next   = rx_state_reg;
        rx_tick_next    = rx_tick_reg;
        rx_bit_next     = rx_bit_reg;
        rx_shift_next   = rx_shift_reg;
        rx_par_bad_next = rx_par_bad_reg;
        rx_push         = 1'b0;
        set_frame       = 1'b0;
        set_parity      = 1'b0;
        case (rx_state_reg)
            S_IDLE: if (!rx_sync_reg) begin
                rx_state_next   = S_START;
                rx_tick_next    = '0;
                rx_par_bad_next = 1'b0;
            end
            S_START: if (tick) begin
                // Mid-start sample; a high line here was only a glitch.
                if (rx_tick_reg == 4'd7) begin
                    rx_state_next = rx_sync_reg ? S_IDLE : S_DATA;
                    rx_tick_next  = '0;
                    rx_bit_next   = '0;
                end else rx_tick_next = rx_tick_reg + 4'd1;
            end
            S_DATA: if (tick) begin
                if (rx_tick_reg == 4'd15) begin
                    rx_tick_next  = '0;
                    rx_bit_next   = rx_bit_reg + 3'd1;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
                    if (rx_bit_reg == LAST_BIT) rx_state_next = HAS_PARITY ? S_PARITY : S_STOP;
                end else rx_tick_next = rx_tick_reg + 4'd1;
            end
            S_PARITY: if (tick) begin
                if (rx_tick_reg == 4'd15) begin
                    rx_tick_next    = '0;
                    rx_par_bad_next = rx_sync_reg != ((^rx_shift_reg) ^ PAR_ODD);
                    rx_state_next   = S_STOP;
                end else rx_tick_next = rx_tick_reg + 4'd1;
            end
            S_STOP: if (tick) begin
                if (rx_tick_reg == 4'd15) begin
                    rx_state_next = S_IDLE;
                    set_frame     = !rx_sync_reg;
                    set_parity    = rx_par_bad_reg;
                    rx_push       = rx_sync_reg && !rx_par_bad_reg;
                end else rx_tick_next = rx_tick_reg + 4'd1;
            end
            default: rx_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_tick_next  = tx_tick_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_par_next   = tx_par_reg;
        tx_pop        = 1'b0;
        tx_next       = 1'b1;
        case (tx_state_reg)
            S_IDLE: tx_pop = tick && (tx_count != '0);
            S_START: if (tick) begin
                if (tx_tick_reg == 4'd15) begin
                    tx_state_next = S_DATA;
                    tx_tick_next  = '0;
                    tx_bit_next   = '0;
                end else tx_tick_next = tx_tick_reg + 4'd1;
            end
            S_DATA: if (tick) begin
                if (tx_tick_reg == 4'd15) begin
                    tx_tick_next  = '0;
                    tx_bit_next   = tx_bit_reg + 3'd1;
                    tx_shift_next = tx_shift_reg >> 1;
                    if (tx_bit_reg == LAST_BIT) tx_state_next = HAS_PARITY ? S_PARITY : S_STOP;
                end else tx_tick_next = tx_tick_reg + 4'd1;
            end
            S_PARITY: if (tick) begin
                if (tx_tick_reg == 4'd15) begin
                    tx_tick_next  = '0;
                    tx_state_next = S_STOP;
                end else tx_tick_next = tx_tick_reg + 4'd1;
            end
            S_STOP: if (tick) begin
                // Chain straight into the next frame when more data is queued.
                if (tx_tick_reg == 4'd15) begin
                    if (tx_count != '0) tx_pop = 1'b1;
                    else tx_state_next = S_IDLE;
                end else tx_tick_next = tx_tick_reg + 4'd1;
            end
            default: tx_state_next = S_IDLE;
        endcase
        if (tx_pop) begin
            tx_state_next = S_START;
            tx_tick_next  = '0;
            tx_shift_next = tx_head;
            tx_par_next   = (^tx_head) ^ PAR_ODD;
        end
        case (tx_state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = tx_shift_next[0];
            S_PARITY: tx_next = tx_par_next;
            default:  tx_next = 1'b1;
        endcase
    end

    assign rx_pop      = rx_valid && rx_ready;
    assign set_overrun = rx_push && rx_full && !rx_pop;

    uart_fifo_buf #(.DW(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .wr_en(rx_push), .wr_data(rx_shift_reg),
        .rd_en(rx_ready), .rd_data(rx_data), .count(rx_count), .full(rx_full)
    );

    uart_fifo_buf #(.DW(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .wr_en(tx_valid), .wr_data(tx_data),
        .rd_en(tx_pop), .rd_data(tx_head), .count(tx_count), .full(tx_full)
    );

    assign tx            = tx_reg;
    assign tx_ready      = !tx_full;
    assign rx_valid      = (rx_count != '0);
    assign rx_overrun    = overrun_reg;
    assign rx_frame_err  = frame_err_reg;
    assign rx_parity_err = parity_err_reg;
endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboarded bench for uart_fifo_core: TX decode, RX frames, overrun, framing/parity errors, reset abort.
module tb_uart_fifo_core;
    localparam int BIT = 208;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, err_clear;
    logic       rx_m, rx_p, tx_m, tx_p;
    logic [7:0] tx_data, rx_data, rx_data_p;
    logic       tx_valid, tx_valid_p, tx_ready, tx_ready_p;
    logic       rx_valid, rx_valid_p, rx_ready, rx_ready_p;
    logic [4:0] rx_count, tx_count, rx_count_p, tx_count_p;
    logic       ovr, ferr, perr, ovr_p, ferr_p, perr_p;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];

    uart_fifo_core #(.CLK_DIV(13), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(16)) u_dut (
        .clk(clk), .reset(reset), .rx(rx_m), .tx(tx_m),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_count(rx_count), .tx_count(tx_count),
        .rx_overrun(ovr), .rx_frame_err(ferr), .rx_parity_err(perr), .err_clear(err_clear)
    );

    uart_fifo_core #(.CLK_DIV(13), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(16)) u_dut_par (
        .clk(clk), .reset(reset), .rx(rx_p), .tx(tx_p),
        .tx_data(tx_data), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
        .rx_count(rx_count_p), .tx_count(tx_count_p),
        .rx_overrun(ovr_p), .rx_frame_err(ferr_p), .rx_parity_err(perr_p), .err_clear(err_clear)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic line_set(input bit which, input logic v);
        if (which) rx_p = v;
        else rx_m = v;
    endtask

    // Parity bit is only sent to the parity-enabled instance; a bad stop is low for just over half a bit.
    task automatic send_rx(input bit which, input logic [7:0] d, input bit bad_stop, input bit par_flip);
        line_set(which, 1'b0);
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            line_set(which, d[i]);
            hold(BIT);
        end
        if (which) begin
            line_set(which, (^d) ^ par_flip);
            hold(BIT);
        end
        if (bad_stop) begin
            line_set(which, 1'b0);
            hold(120);
            line_set(which, 1'b1);
            hold(BIT - 120);
        end else begin
            line_set(which, 1'b1);
            hold(BIT);
        end
        $display("[TB] rx frame 0x%02h dut%0d bad_stop=%0d par_flip=%0d", d, which, bad_stop, par_flip);
    endtask

    task automatic rx_pop_check(input string tag);
        logic [7:0] exp;
        check({tag, "_valid"}, rx_valid, 1);
        exp = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'h00;
        check(tag, rx_data, exp);
        $display("[TB] rx pop 0x%02h expected 0x%02h", rx_data, exp);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        check("tx_ready", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_exp.push_back(b);
        $display("[TB] tx push 0x%02h", b);
    endtask

    // Decode one frame from tx_m; lowlen = start-bit low time (capped), wt = idle cycles before it.
    task automatic tx_recv(output int lowlen, output int wt);
        logic [7:0] d;
        logic [7:0] exp;
        int el;
        d = '0;
        wt = 0;
        lowlen = 0;
        while (tx_m === 1'b1 && wt < 3000) begin
            @(negedge clk);
            wt++;
        end
        if (wt >= 3000) begin
            check("tx_timeout", 0, 1);
            return;
        end
        while (tx_m === 1'b0 && lowlen < 210) begin
            @(negedge clk);
            lowlen++;
        end
        el = lowlen;
        for (int i = 0; i < 9; i++) begin
            hold(104 + BIT * (i + 1) - el);
            el = 104 + BIT * (i + 1);
            if (i < 8) d[i] = tx_m;
            else check("tx_stop", tx_m, 1);
        end
        exp = (tx_exp.size() != 0) ? tx_exp.pop_front() : 8'h00;
        check("tx_byte", d, exp);
        $display("[TB] tx frame 0x%02h expected 0x%02h start_len=%0d wait=%0d", d, exp, lowlen, wt);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowlen, wt, t;
        logic [7:0] b;
        reset = 1'b1; err_clear = 1'b0;
        rx_m = 1'b1; rx_p = 1'b1;
        rx_ready = 1'b0; rx_ready_p = 1'b0;
        tx_valid = 1'b0; tx_valid_p = 1'b0; tx_data = '0;
        hold(5);
        check("rst_tx", tx_m, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_counts", {rx_count, tx_count}, 0);
        check("rst_flags", {ovr, ferr, perr}, 0);
        reset = 1'b0;
        hold(5);

        push_tx(8'hA5);
        check("tx_count_1", tx_count, 1);
        tx_recv(lowlen, wt);
        check("tx_start_len", (lowlen >= 207 && lowlen <= 209), 1);
        check("tx_latency", (wt >= 1 && wt <= 13), 1);
        check("tx_count_0", tx_count, 0);

        push_tx(8'h81);
        push_tx(8'h7E);
        tx_recv(lowlen, wt);
        tx_recv(lowlen, wt);
        check("tx_b2b_gap", (wt >= 103 && wt <= 105), 1);
        hold(BIT);

        rx_exp.push_back(8'h3C);
        send_rx(1'b0, 8'h3C, 1'b0, 1'b0);
        check("rx_count_1", rx_count, 1);
        rx_pop_check("rx_3c");
        check("rx_valid_after_pop", rx_valid, 0);

        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 37 + 5);
            if (i < 16) rx_exp.push_back(b);
            send_rx(1'b0, b, 1'b0, 1'b0);
            if (i == 15) check("ovr_not_yet", ovr, 0);
        end
        check("ovr_count", rx_count, 16);
        check("ovr_flag", ovr, 1);
        for (int i = 0; i < 16; i++) rx_pop_check("ovr_data");
        check("ovr_drained", rx_count, 0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("ovr_cleared", ovr, 0);

        send_rx(1'b0, 8'h55, 1'b1, 1'b0);
        check("ferr_no_push", rx_count, 0);
        check("ferr_flag", ferr, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("ferr_cleared", ferr, 0);

        send_rx(1'b1, 8'h01, 1'b0, 1'b1);
        check("perr_no_push", rx_count_p, 0);
        check("perr_flag", perr_p, 1);
        check("perr_no_ferr", ferr_p, 0);
        send_rx(1'b1, 8'h01, 1'b0, 1'b0);
        check("par_good_count", rx_count_p, 1);
        check("par_good_data", rx_data_p, 8'h01);
        check("perr_sticky", perr_p, 1);

        rx_m = 1'b0;
        hold(39);
        rx_m = 1'b1;
        hold(2 * BIT);
        check("glitch_no_push", rx_count, 0);
        check("glitch_no_ferr", ferr, 0);
        rx_exp.push_back(8'hC3);
        send_rx(1'b0, 8'hC3, 1'b0, 1'b0);
        rx_pop_check("rx_after_glitch");

        push_tx(8'h00);
        push_tx(8'hFF);
        tx_exp.delete();
        t = 0;
        while (tx_m === 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("rst_mid_started", tx_m, 0);
        hold(500);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", tx_m, 1);
        check("rst_mid_count", tx_count, 0);
        check("rst_mid_ready", tx_ready, 1);
        reset = 1'b0;
        hold(300);
        check("rst_mid_idle", tx_m, 1);
        $display("[TB] reset mid-frame done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
